// File: rtl/rs_sched_pkg.sv
// Shared types and one-hot helpers for the reservation-station issue scheduler.
package rs_sched_pkg;

    // Helpers work on a fixed maximum width; callers zero-extend and slice.
    localparam int MAX_RS    = 32;
    localparam int MAX_IDX_W = 5;

    typedef enum logic {
        OPEN    = 1'b0,
        BLOCKED = 1'b1
    } sched_state_t;

    // Keep only the lowest set bit (all zeros if none set).
    function automatic logic [MAX_RS-1:0] onehot_lowest(input logic [MAX_RS-1:0] vec);
        logic [MAX_RS-1:0] oh;
        oh = '0;
        for (int i = MAX_RS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Binary index of a one-hot vector (0 when empty).
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_RS-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_RS; i++) begin
            if (vec[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: older[i][j] = 1 means station i was allocated before station j.
// Picks the oldest ready candidate.
module rs_age_matrix
    import rs_sched_pkg::*;
#(
    parameter int NUM_RS = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [NUM_RS-1:0] alloc,
    input  logic [NUM_RS-1:0] busy,
    input  logic [NUM_RS-1:0] cand,
    output logic [NUM_RS-1:0] winner
);

    logic [NUM_RS-1:0][NUM_RS-1:0] older;
    logic [NUM_RS-1:0]             no_older;
    logic [MAX_RS-1:0]             pick;
    logic                          unused_pick;

    // New slot is younger than every busy slot; its own row starts empty.
    always_ff @(posedge clk) begin
        if (clear) begin
            older <= '0;
        end else begin
            for (int r = 0; r < NUM_RS; r++) begin
                for (int c = 0; c < NUM_RS; c++) begin
                    if (alloc[r])
                        older[r][c] <= 1'b0;
                    else if (alloc[c] && busy[r])
                        older[r][c] <= 1'b1;
                end
            end
        end
    end

    // A candidate wins when no other candidate is older than it.
    always_comb begin
        no_older = cand;
        for (int w = 0; w < NUM_RS; w++) begin
            for (int j = 0; j < NUM_RS; j++) begin
                if (cand[j] && older[j][w]) no_older[w] = 1'b0;
            end
        end
    end

    // Guard keeps the grant one-hot even if stale state ever produced a tie.
    assign pick        = onehot_lowest(MAX_RS'(no_older));
    assign winner      = pick[NUM_RS-1:0];
    assign unused_pick = ^pick;

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: lowest-free allocation, oldest-first issue,
// issue throttling for non-pipelined FUs, and flush on restore.
module rs_issue_scheduler
    import rs_sched_pkg::*;
#(
    parameter int NUM_RS    = 4,
    parameter int ISSUE_GAP = 1,
    parameter int GAP_W     = $clog2(ISSUE_GAP + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      needToRestore_i,
    input  logic                      decodeWriteEn_i,
    input  logic [NUM_RS-1:0]         rsBusy_i,
    input  logic [NUM_RS-1:0]         rsReady_i,
    input  logic                      fuReady_i,
    output logic [NUM_RS-1:0]         rsWriteEn_o,
    output logic                      decodeStall_o,
    output logic [NUM_RS-1:0]         rsStall_o,
    output logic                      issueValid_o,
    output logic [$clog2(NUM_RS)-1:0] issueIdx_o
);

    localparam int IDX_W = $clog2(NUM_RS);

    logic                 flush;
    logic [NUM_RS-1:0]    free;
    logic                 any_free;
    logic [MAX_RS-1:0]    alloc_ext;
    logic [NUM_RS-1:0]    alloc_vec;
    logic [NUM_RS-1:0]    cand;
    logic [NUM_RS-1:0]    winner;
    logic [MAX_IDX_W-1:0] win_idx;
    logic                 issue;
    logic                 unused_bits;
    sched_state_t         state, state_nxt;
    logic [GAP_W-1:0]     cnt, cnt_nxt;

    assign flush    = reset_i | needToRestore_i;

    // Allocation: lowest idle station takes the decoded op. An issuing
    // station is still busy, so it only becomes allocatable next cycle.
    assign free          = ~rsBusy_i;
    assign any_free      = |free;
    assign alloc_ext     = onehot_lowest(MAX_RS'(free));
    assign alloc_vec     = (decodeWriteEn_i && any_free && !flush) ? alloc_ext[NUM_RS-1:0] : '0;
    assign rsWriteEn_o   = alloc_vec;
    assign decodeStall_o = decodeWriteEn_i & ~any_free & ~flush;

    assign cand = rsReady_i & rsBusy_i;

    rs_age_matrix #(.NUM_RS(NUM_RS)) u_age (
        .clk    (clk_i),
        .clear  (flush),
        .alloc  (alloc_vec),
        .busy   (rsBusy_i),
        .cand   (cand),
        .winner (winner)
    );

    assign win_idx      = onehot_to_idx(MAX_RS'(winner));
    assign issue        = (|cand) & fuReady_i & (state == OPEN) & ~flush;
    assign issueValid_o = issue;
    assign issueIdx_o   = issue ? win_idx[IDX_W-1:0] : '0;
    assign rsStall_o    = issue ? ~winner : '1;
    assign unused_bits  = ^{alloc_ext, win_idx};

    // Throttle state register; flush reopens issue immediately.
    always_ff @(posedge clk_i) begin
        if (reset_i || needToRestore_i) begin
            state <= OPEN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // After an issue, hold off ISSUE_GAP-1 cycles before the next one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OPEN: begin
                if (issue && ISSUE_GAP > 1) begin
                    state_nxt = BLOCKED;
                    cnt_nxt   = GAP_W'(ISSUE_GAP - 1);
                end
            end
            BLOCKED: begin
                if (cnt <= GAP_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = OPEN;
                end else begin
                    cnt_nxt = cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = OPEN;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
